// File: rtl/pwm_pkg.sv
// Shared encodings for the multi-channel PWM: counting modes and counter direction.
package pwm_pkg;

  localparam logic MODE_EDGE   = 1'b0;
  localparam logic MODE_CENTER = 1'b1;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

endpackage

// File: rtl/pwm_multi_if.sv
// Register-side configuration and PWM output bundle for pwm_multi.
interface pwm_multi_if #(
  parameter int CH      = 4,
  parameter int CNT_W   = 10,
  parameter int PRESC_W = 8
);
  logic                  enable;
  logic                  mode;
  logic [PRESC_W-1:0]    prescale;
  logic [CNT_W-1:0]      period;
  logic [CH*CNT_W-1:0]   duty;
  logic [CH-1:0]         polarity;
  logic [CH-1:0]         ch_en;
  logic [CH-1:0]         pwm;
  logic                  period_tick;

  modport master (
    output enable, mode, prescale, period, duty, polarity, ch_en,
    input  pwm, period_tick
  );

  modport slave (
    input  enable, mode, prescale, period, duty, polarity, ch_en,
    output pwm, period_tick
  );
endinterface

// File: rtl/pwm_channel.sv
// One PWM channel: compares the shared counter with its duty, applies polarity,
// and falls back to the live idle level whenever the channel is not running.
module pwm_channel #(
  parameter int CNT_W = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             ch_en,
  input  logic [CNT_W-1:0] cnt,
  input  logic [CNT_W-1:0] duty,
  input  logic             pol_sh,
  input  logic             pol_live,
  output logic             pwm
);
  logic raw;
  logic pwm_next;
  logic pwm_reg;

  always_comb begin
    raw      = (cnt < duty);
    pwm_next = pol_live;
    if (active && ch_en) begin
      pwm_next = raw ^ pol_sh;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pwm_reg <= 1'b0;
    end else begin
      pwm_reg <= pwm_next;
    end
  end

  assign pwm = pwm_reg;
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: shared prescaler/counter timebase with double-buffered
// settings, feeding CH compare channels.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter int CH      = 4,
  parameter int CNT_W   = 10,
  parameter int PRESC_W = 8
) (
  input  logic        clk,
  input  logic        reset,
  pwm_multi_if.slave  bus
);
  logic [PRESC_W-1:0]  presc_reg, presc_next, prescale_sh_reg;
  logic [CNT_W-1:0]    cnt_reg, cnt_next, period_sh_reg;
  dir_e                dir_reg, dir_next;
  logic [CH*CNT_W-1:0] duty_sh_reg;
  logic [CH-1:0]       polarity_sh_reg;
  logic                mode_sh_reg;
  logic                enable_d_reg;
  logic                period_tick_reg;
  logic                run, tick, boundary, load_sh;
  logic [CNT_W-1:0]    top;
  logic [CH-1:0]       pwm_bits;

  // The rising-enable clock only loads shadows; counting starts on the next clock.
  assign run  = bus.enable & enable_d_reg;
  assign tick = run && (presc_reg == prescale_sh_reg);
  assign top  = (period_sh_reg == '0) ? CNT_W'(1) : period_sh_reg;

  always_comb begin
    presc_next = presc_reg;
    cnt_next   = cnt_reg;
    dir_next   = dir_reg;
    boundary   = 1'b0;
    if (!run) begin
      presc_next = '0;
      cnt_next   = '0;
      dir_next   = DIR_UP;
    end else if (tick) begin
      presc_next = '0;
      case (mode_sh_reg)
        MODE_EDGE: begin
          dir_next = DIR_UP;
          if (cnt_reg >= period_sh_reg) begin
            boundary = 1'b1;
            cnt_next = '0;
          end else begin
            cnt_next = cnt_reg + CNT_W'(1);
          end
        end
        MODE_CENTER: begin
          // Turnaround ticks hold the count so top and bottom each last two ticks.
          if (dir_reg == DIR_UP) begin
            if (cnt_reg >= top - CNT_W'(1)) dir_next = DIR_DOWN;
            else                            cnt_next = cnt_reg + CNT_W'(1);
          end else if (cnt_reg == '0) begin
            boundary = 1'b1;
            dir_next = DIR_UP;
          end else begin
            cnt_next = cnt_reg - CNT_W'(1);
          end
        end
      endcase
    end else begin
      presc_next = presc_reg + PRESC_W'(1);
    end
    load_sh = (bus.enable & ~enable_d_reg) | boundary;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      presc_reg       <= '0;
      cnt_reg         <= '0;
      dir_reg         <= DIR_UP;
      prescale_sh_reg <= '0;
      period_sh_reg   <= '0;
      duty_sh_reg     <= '0;
      polarity_sh_reg <= '0;
      mode_sh_reg     <= MODE_EDGE;
      enable_d_reg    <= 1'b0;
      period_tick_reg <= 1'b0;
    end else begin
      presc_reg       <= presc_next;
      cnt_reg         <= cnt_next;
      dir_reg         <= dir_next;
      enable_d_reg    <= bus.enable;
      period_tick_reg <= boundary;
      if (load_sh) begin
        prescale_sh_reg <= bus.prescale;
        period_sh_reg   <= bus.period;
        duty_sh_reg     <= bus.duty;
        polarity_sh_reg <= bus.polarity;
        mode_sh_reg     <= bus.mode;
      end
    end
  end

  for (genvar gi = 0; gi < CH; gi++) begin : g_ch
    pwm_channel #(.CNT_W(CNT_W)) u_ch (
      .clk     (clk),
      .reset   (reset),
      .active  (run),
      .ch_en   (bus.ch_en[gi]),
      .cnt     (cnt_reg),
      .duty    (duty_sh_reg[gi*CNT_W +: CNT_W]),
      .pol_sh  (polarity_sh_reg[gi]),
      .pol_live(bus.polarity[gi]),
      .pwm     (pwm_bits[gi])
    );
  end

  assign bus.pwm         = pwm_bits;
  assign bus.period_tick = period_tick_reg;
endmodule

// File: tb/tb_pwm_multi.sv
// Directed-vector bench for pwm_multi; expected waveforms are hand-derived bit patterns.
module tb_pwm_multi;
  import pwm_pkg::*;

  localparam int CH      = 4;
  localparam int CNT_W   = 10;
  localparam int PRESC_W = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pwm_multi_if #(.CH(CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) bus ();

  pwm_multi #(.CH(CH), .CNT_W(CNT_W), .PRESC_W(PRESC_W)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [CH-1:0] pwm_s  [64];
  logic          tick_s [64];

  task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end else begin
      $display("[TB] ok %s = 0x%0h", tag, actual);
    end
  endtask

  task automatic capture(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_s[i]  = bus.pwm;
      tick_s[i] = bus.period_tick;
    end
  endtask

  function automatic logic [63:0] pwm_vec(input int ch, input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = pwm_s[i][ch];
    return v;
  endfunction

  function automatic logic [63:0] tick_vec(input int n);
    logic [63:0] v = '0;
    for (int i = 0; i < n; i++) v[i] = tick_s[i];
    return v;
  endfunction

  task automatic wait_tick(input string tag);
    logic seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.period_tick === 1'b1) seen = 1'b1;
    end
    check_eq(tag, seen, 1);
  endtask

  task automatic start_run(input logic m, input logic [PRESC_W-1:0] ps, input logic [CNT_W-1:0] p,
                           input logic [CH*CNT_W-1:0] d, input logic [CH-1:0] pol, input logic [CH-1:0] en);
    bus.enable = 1'b0;
    @(negedge clk);
    bus.mode     = m;
    bus.prescale = ps;
    bus.period   = p;
    bus.duty     = d;
    bus.polarity = pol;
    bus.ch_en    = en;
    bus.enable   = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected $finish");
    $fatal(1);
  end

  initial begin
    logic [2:0]  or_hi;
    logic        and2, and3, or1;
    int          hi0;

    reset        = 1'b0;
    bus.enable   = 1'b0;
    bus.mode     = MODE_EDGE;
    bus.prescale = '0;
    bus.period   = '0;
    bus.duty     = '0;
    bus.polarity = 4'b1111;
    bus.ch_en    = '0;
    repeat (2) @(negedge clk);
    check_eq("reset_pwm", bus.pwm, 0);
    check_eq("reset_tick", bus.period_tick, 0);

    // Disabled outputs follow the live polarity.
    reset        = 1'b1;
    bus.polarity = 4'b0101;
    @(negedge clk);
    check_eq("idle_polarity", bus.pwm, 4'b0101);

    // Edge mode, P=9, duty0=3: first period from enable, then a steady period.
    start_run(MODE_EDGE, 0, 9, {10'd0, 10'd0, 10'd0, 10'd3}, 4'b0000, 4'b0001);
    capture(11);
    check_eq("t1_first_pwm0", pwm_vec(0, 11), 64'h00E);
    check_eq("t1_first_tick", tick_vec(11), 64'h400);
    capture(10);
    check_eq("t1_pwm0", pwm_vec(0, 10), 64'h007);
    check_eq("t1_tick", tick_vec(10), 64'h200);
    or_hi = '0;
    for (int i = 0; i < 10; i++) or_hi |= pwm_s[i][3:1];
    check_eq("t1_unused_ch_low", or_hi, 0);

    // Duty extremes and a disabled inverted channel.
    start_run(MODE_EDGE, 0, 9, {10'd0, 10'd10, 10'd0, 10'd3}, 4'b1000, 4'b0111);
    capture(21);
    and2 = 1'b1; and3 = 1'b1; or1 = 1'b0; hi0 = 0;
    for (int i = 0; i < 21; i++) begin
      and3 &= pwm_s[i][3];
      if (i > 0) begin
        and2 &= pwm_s[i][2];
        or1  |= pwm_s[i][1];
        hi0  += int'(pwm_s[i][0]);
      end
    end
    check_eq("t2_duty_zero_low", or1, 0);
    check_eq("t2_duty_over_high", and2, 1);
    check_eq("t2_disabled_inverted", and3, 1);
    check_eq("t2_ch0_high_count", hi0, 6);

    // Center mode, P=4, duty0=2.
    start_run(MODE_CENTER, 0, 4, {10'd0, 10'd0, 10'd0, 10'd2}, 4'b0000, 4'b0001);
    wait_tick("t3_tick_seen");
    capture(8);
    check_eq("t3_pwm0", pwm_vec(0, 8), 64'hC3);
    check_eq("t3_tick", tick_vec(8), 64'h80);

    // Prescale 3: each count held 4 clocks.
    start_run(MODE_EDGE, 3, 9, {10'd0, 10'd0, 10'd0, 10'd5}, 4'b0000, 4'b0001);
    wait_tick("t4_tick_seen");
    capture(40);
    check_eq("t4_pwm0", pwm_vec(0, 40), 64'h0F_FFFF);
    check_eq("t4_tick", tick_vec(40), 64'h80_0000_0000);

    // Duty update mid-period only lands after the next boundary.
    start_run(MODE_EDGE, 0, 9, {10'd0, 10'd0, 10'd0, 10'd3}, 4'b0000, 4'b0001);
    wait_tick("t5_tick_seen");
    capture(4);
    check_eq("t5_head_pwm0", pwm_vec(0, 4), 64'h7);
    check_eq("t5_head_tick", tick_vec(4), 0);
    bus.duty = {10'd0, 10'd0, 10'd0, 10'd7};
    capture(6);
    check_eq("t5_tail_pwm0", pwm_vec(0, 6), 0);
    check_eq("t5_tail_tick", tick_vec(6), 64'h20);
    capture(10);
    check_eq("t5_new_pwm0", pwm_vec(0, 10), 64'h07F);
    check_eq("t5_new_tick", tick_vec(10), 64'h200);

    // Asynchronous reset mid-high-phase, then restart via enable.
    capture(2);
    check_eq("t6_pre_reset_pwm0", pwm_vec(0, 2), 64'h3);
    #2;
    reset = 1'b0;
    #1;
    check_eq("t6_async_pwm", bus.pwm, 0);
    check_eq("t6_async_tick", bus.period_tick, 0);
    bus.enable = 1'b0;
    capture(3);
    check_eq("t6_hold_pwm0", pwm_vec(0, 3), 0);
    check_eq("t6_hold_tick", tick_vec(3), 0);
    reset = 1'b1;
    @(negedge clk);
    bus.enable = 1'b1;
    capture(11);
    check_eq("t6_restart_pwm0", pwm_vec(0, 11), 64'h0FE);
    check_eq("t6_restart_tick", tick_vec(11), 64'h400);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
Parametrised multi-channel PWM generator; successor to the single-channel SoC PWM block. It adds per-channel duty and enable, a programmable period and prescaler, per-channel output polarity, and edge- or center-aligned counting. All settings are double-buffered into shadow registers, so updates never produce glitched periods. It sits behind the SoC register interface and drives motor, door and indicator outputs.

Parameters:
CH, 4, number of PWM channels
CNT_W, 10, width of the period counter, period and duty values
PRESC_W, 8, width of the prescaler

Ports:
clk  in  1  system clock
reset  in  1  asynchronous, active-low reset (asserted when 0)
enable  in  1  global run enable
mode  in  1  0 = edge-aligned, 1 = center-aligned
prescale  in  PRESC_W  counter advances once every prescale+1 clocks
period  in  CNT_W  period value P
duty  in  CH*CNT_W  channel i duty is at bits [i*CNT_W +: CNT_W]
polarity  in  CH  1 = channel output inverted (active-low)
ch_en  in  CH  per-channel enable
pwm  out  CH  PWM outputs, registered
period_tick  out  1  one-clock pulse at each period boundary

Behaviour:
- Reset (reset=0, async): prescaler count, counter, direction (up) and all shadows are cleared; pwm=0, period_tick=0.
- Shadows (prescale, period, duty, mode, polarity): loaded on the clock where enable rises (0 to 1), and on every period-boundary clock. At all other times, live input changes have no effect.
- Prescaler: counts 0..prescale_sh. A tick occurs on the clock where it equals prescale_sh, after which it wraps to 0. With prescale_sh=0, every clock is a tick.
- Edge mode: on each tick, the counter goes 0..P then wraps to 0. The boundary is the tick where cnt==P, so the period is P+1 ticks. P=0 gives a boundary on every tick.
- Center mode: the counter sequence is 0,1..P-1,P-1..1,0. The top and bottom values are each held for 2 ticks, so the period is 2P ticks.
  - Up phase: at cnt==P-1 the direction flips to down and cnt holds.
  - Down phase: at cnt==0 the direction flips to up and cnt holds. This tick is the boundary.
  - P=0 is treated as P=1.
- Compare per channel: raw_i = (cnt < duty_sh_i).
  - duty=0 gives constant low.
  - duty>P (edge mode) or duty>=P (center mode) gives constant high.
- Output: pwm_i is registered one clock after the counter value.
  - If enable and ch_en_i: pwm_i = raw_i XOR polarity_sh_i.
  - Otherwise pwm_i = the live polarity_i (idle inactive level).
- period_tick: registered pulse of 1 clock, asserted in the clock after the boundary tick. It is not asserted while disabled.
- enable=0: prescaler and counter are held at 0 and direction is up. When enable next rises, counting restarts from cnt=0 with freshly loaded shadows.
- A mode change takes effect only at a boundary. The counter restarts at 0 going up.
- Reset mid-operation forces the reset state immediately. No period completion and no tick is emitted.

Decomposition:
- Package pwm_pkg holds:
  - MODE_EDGE=1'b0 and MODE_CENTER=1'b0 + 1, i.e. 1'b1;
  - the counter-direction encoding DIR_UP/DIR_DOWN.
- Sub-module pwm_channel (compare, polarity and output register, with idle handling) is instantiated CH times via generate.
- The shared timebase (prescaler, counter, direction, shadows, tick) stays in pwm_multi.

Test Plan:
1. Edge mode, prescale=0, P=9, duty0=3, ch_en=0001, polarity=0 -> pwm[0] high 3 clocks then low 7, repeating every 10 clocks; period_tick every 10 clocks; pwm[3:1]=0.
2. Edge mode, P=9, duty1=0, duty2=10, polarity3=1 with ch_en3=0 -> pwm[1] constant 0; pwm[2] constant 1; pwm[3] constant 1.
3. Center mode, prescale=0, P=4, duty0=2 -> cnt 0,1,2,3,3,2,1,0; pwm[0] high on period clocks 0,1,6,7 (4 of 8); period_tick every 8 clocks.
4. prescale=3, edge mode, P=9, duty0=5 -> each count held 4 clocks; 40-clock period with 20 clocks high.
5. Edge mode, P=9, duty0=3; change duty0 to 7 mid-period -> the current period still shows 3 high; the period after the next period_tick shows 7 high.
6. Running; pull reset low mid-period, then release; then toggle enable 0 to 1 -> pwm=0 and period_tick=0 immediately on reset; after enable rises, counting restarts at cnt=0 with the first high phase intact.
